// File: rtl/lif_synapse.sv
// Purpose: presynaptic front end; weights spike events, sums them per timestep,
//          delays the sums by DELAY ticks and folds them into a decaying current.
// Latency: synaptic_out/out_valid valid the cycle after tick; back-pressure: spike_ready low during UPDATE.
module lif_synapse #(
  parameter int N_IN      = 4,
  parameter int DELAY     = 2,
  parameter int TAU_SHIFT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      spike_valid,
  input  logic [$clog2(N_IN)-1:0]   spike_id,
  output logic                      spike_ready,
  input  logic                      wr_en,
  input  logic [$clog2(N_IN)-1:0]   wr_addr,
  input  logic signed [15:0]        wr_data,
  output logic signed [15:0]        synaptic_out,
  output logic                      out_valid,
  output logic                      tick_overrun
);

  localparam logic signed [17:0] SAT_MAX = 18'sd32767;
  localparam logic signed [17:0] SAT_MIN = -18'sd32768;

  typedef enum logic {ACCUM, UPDATE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic signed [15:0]    weight [N_IN];
  logic signed [15:0]    acc;
  logic signed [15:0]    w_sel;
  logic signed [15:0]    closed;
  logic signed [15:0]    due;
  logic signed [17:0]    acc_ext;
  logic signed [17:0]    w_ext;
  logic signed [17:0]    cur_ext;
  logic signed [17:0]    due_ext;
  logic signed [17:0]    cur_upd;
  logic                  accepted;
  logic                  tick_acc;

  // Clamp an 18-bit signed intermediate into the 16-bit signed range.
  function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
    if (v > SAT_MAX)      return 16'sh7fff;
    else if (v < SAT_MIN) return 16'sh8000;
    else                  return v[15:0];
  endfunction

  assign accepted = spike_valid && spike_ready;
  assign tick_acc = tick && (state == ACCUM);

  // Weight lookup; out-of-range source ids carry no weight.
  always_comb begin
    w_sel = '0;
    if (32'(spike_id) < N_IN) w_sel = weight[spike_id];
  end

  // Timestep sum including an event accepted on the closing cycle.
  always_comb begin
    acc_ext = acc;
    w_ext   = w_sel;
    closed  = accepted ? sat16(acc_ext + w_ext) : acc;
  end

  // Leaky update: I - (I >>> TAU_SHIFT) + due; positive residues below 2^TAU_SHIFT stick by design.
  always_comb begin
    cur_ext = synaptic_out;
    due_ext = due;
    cur_upd = cur_ext - (cur_ext >>> TAU_SHIFT) + due_ext;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACCUM;
    else      state <= state_nxt;
  end

  // Next state and handshake/strobe outputs.
  always_comb begin
    state_nxt   = state;
    spike_ready = 1'b0;
    out_valid   = 1'b0;
    case (state)
      ACCUM: begin
        spike_ready = 1'b1;
        if (tick) state_nxt = UPDATE;
      end
      UPDATE: begin
        out_valid = 1'b1;
        state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Weight RAM: a write lands next cycle, so a same-cycle spike reads the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_IN; i++) weight[i] <= '0;
    end else if (wr_en && (32'(wr_addr) < N_IN)) begin
      weight[wr_addr] <= wr_data;
    end
  end

  // Per-timestep accumulator; cleared when the timestep closes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          acc <= '0;
    else if (tick_acc) acc <= '0;
    else if (accepted) acc <= closed;
  end

  // Axonal delay line: the tail value is the sum closed DELAY ticks ago.
  generate
    if (DELAY > 0) begin : g_dly
      logic signed [15:0] dly [DELAY];
      // Shift one stage per accepted tick.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DELAY; i++) dly[i] <= '0;
        end else if (tick_acc) begin
          dly[0] <= closed;
          for (int i = 1; i < DELAY; i++) dly[i] <= dly[i-1];
        end
      end
      assign due = dly[DELAY-1];
    end else begin : g_nodly
      assign due = closed;
    end
  endgenerate

  // Current register, loaded on the accepted tick so it is visible during UPDATE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          synaptic_out <= '0;
    else if (tick_acc) synaptic_out <= sat16(cur_upd);
  end

  // Sticky flag for ticks that land while the update is still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             tick_overrun <= 1'b0;
    else if (tick && (state == UPDATE))   tick_overrun <= 1'b1;
  end

endmodule

// File: tb/tb_lif_synapse.sv
// Bench for lif_synapse: two instances (DELAY=2 and DELAY=0) share one stimulus stream.
// Every cycle both are compared against a queue-based model of the timestep rules.
module tb_lif_synapse;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, tick, spike_valid, wr_en;
  logic [1:0]         spike_id, wr_addr;
  logic signed [15:0] wr_data;
  logic               rdy2, rdy0, vld2, vld0, ovr2, ovr0;
  logic signed [15:0] out2, out0;

  lif_synapse #(.N_IN(4), .DELAY(2), .TAU_SHIFT(1)) u_d2 (
    .clk(clk), .rst(rst), .tick(tick), .spike_valid(spike_valid), .spike_id(spike_id),
    .spike_ready(rdy2), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .synaptic_out(out2), .out_valid(vld2), .tick_overrun(ovr2));

  lif_synapse #(.N_IN(4), .DELAY(0), .TAU_SHIFT(1)) u_d0 (
    .clk(clk), .rst(rst), .tick(tick), .spike_valid(spike_valid), .spike_id(spike_id),
    .spike_ready(rdy0), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .synaptic_out(out0), .out_valid(vld0), .tick_overrun(ovr0));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int w_m [4];
  int acc_m;
  int cur2_m, cur0_m;
  int dq2 [$];
  bit busy_m, ovr_m, vld_m;

  function automatic int sat(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) w_m[i] = 0;
    acc_m = 0; cur2_m = 0; cur0_m = 0;
    busy_m = 0; ovr_m = 0; vld_m = 0;
    dq2.delete();
    repeat (2) dq2.push_back(0);
  endtask

  task automatic model_step();
    int  wsel, closed, due2;
    bit  take;
    wsel = w_m[spike_id];
    take = spike_valid && !busy_m;
    if (tick && !busy_m) begin
      closed = take ? sat(acc_m + wsel) : acc_m;
      dq2.push_back(closed);
      due2   = dq2.pop_front();
      cur2_m = sat(cur2_m - (cur2_m >>> 1) + due2);
      cur0_m = sat(cur0_m - (cur0_m >>> 1) + closed);
      acc_m  = 0;
      vld_m  = 1;
      busy_m = 1;
    end else begin
      if (tick && busy_m) ovr_m = 1;
      if (take) acc_m = sat(acc_m + wsel);
      vld_m  = 0;
      busy_m = 0;
    end
    if (wr_en) w_m[wr_addr] = int'(wr_data);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("rdy_d2", int'(rdy2), int'(!busy_m));
    chk("rdy_d0", int'(rdy0), int'(!busy_m));
    chk("vld_d2", int'(vld2), int'(vld_m));
    chk("vld_d0", int'(vld0), int'(vld_m));
    chk("ovr_d2", int'(ovr2), int'(ovr_m));
    chk("ovr_d0", int'(ovr0), int'(ovr_m));
    chk("out_d2", int'(out2), cur2_m);
    chk("out_d0", int'(out0), cur0_m);
  endtask

  task automatic drive(input bit t, input bit sv, input logic [1:0] sid,
                       input bit we, input logic [1:0] wa, input int wd);
    tick = t; spike_valid = sv; spike_id = sid;
    wr_en = we; wr_addr = wa; wr_data = 16'(wd);
  endtask

  task automatic cyc(input bit t, input bit sv, input logic [1:0] sid,
                     input bit we, input logic [1:0] wa, input int wd);
    drive(t, sv, sid, we, wa, wd);
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    drive(0, 0, 2'd0, 0, 2'd0, 0);
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  typedef struct {
    bit         t;
    bit         sv;
    logic [1:0] sid;
    bit         we;
    logic [1:0] wa;
    int         wd;
    int         e2;
    int         e0;
    bit         ev;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst = 1'b1;
    drive(0, 0, 2'd0, 0, 2'd0, 0);
    #2;

    // Delay/decay vectors: w0=100, one spike, then five ticks.
    tbl[0]  = '{0, 0, 2'd0, 1, 2'd0, 100,   0,   0, 0};
    tbl[1]  = '{0, 1, 2'd0, 0, 2'd0,   0,   0,   0, 0};
    tbl[2]  = '{1, 0, 2'd0, 0, 2'd0,   0,   0, 100, 1};
    tbl[3]  = '{0, 0, 2'd0, 0, 2'd0,   0,   0, 100, 0};
    tbl[4]  = '{1, 0, 2'd0, 0, 2'd0,   0,   0,  50, 1};
    tbl[5]  = '{0, 0, 2'd0, 0, 2'd0,   0,   0,  50, 0};
    tbl[6]  = '{1, 0, 2'd0, 0, 2'd0,   0, 100,  25, 1};
    tbl[7]  = '{0, 0, 2'd0, 0, 2'd0,   0, 100,  25, 0};
    tbl[8]  = '{1, 0, 2'd0, 0, 2'd0,   0,  50,  13, 1};
    tbl[9]  = '{0, 0, 2'd0, 0, 2'd0,   0,  50,  13, 0};
    tbl[10] = '{1, 0, 2'd0, 0, 2'd0,   0,  25,   7, 1};
    tbl[11] = '{0, 0, 2'd0, 0, 2'd0,   0,  25,   7, 0};

    do_reset();
    chk("reset_out", int'(out2), 0);
    chk("reset_rdy", int'(rdy2), 1);
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].t, tbl[i].sv, tbl[i].sid, tbl[i].we, tbl[i].wa, tbl[i].wd);
      chk($sformatf("tbl%0d_out_d2", i), int'(out2), tbl[i].e2);
      chk($sformatf("tbl%0d_out_d0", i), int'(out0), tbl[i].e0);
      chk($sformatf("tbl%0d_vld", i),    int'(vld2), int'(tbl[i].ev));
      chk($sformatf("tbl%0d_rdy", i),    int'(rdy2), int'(!tbl[i].ev));
    end

    // Same-cycle spike on tick, and a spike held across UPDATE.
    do_reset();
    cyc(0, 0, 2'd0, 1, 2'd0, 10);
    cyc(1, 1, 2'd0, 0, 2'd0, 0);
    chk("samecyc_out_d0", int'(out0), 10);
    chk("update_rdy", int'(rdy0), 0);
    cyc(0, 1, 2'd0, 0, 2'd0, 0);
    chk("after_update_rdy", int'(rdy0), 1);
    cyc(0, 1, 2'd0, 0, 2'd0, 0);
    cyc(1, 0, 2'd0, 0, 2'd0, 0);
    chk("held_spike_out_d0", int'(out0), 15);
    cyc(0, 0, 2'd0, 0, 2'd0, 0);

    // Overrun: back-to-back ticks.
    do_reset();
    pulses = 0;
    cyc(1, 0, 2'd0, 0, 2'd0, 0); pulses += int'(vld2);
    chk("ovr_first", int'(ovr2), 0);
    cyc(1, 0, 2'd0, 0, 2'd0, 0); pulses += int'(vld2);
    chk("ovr_set", int'(ovr2), 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 2'd0, 0, 2'd0, 0); pulses += int'(vld2);
    end
    chk("ovr_sticky", int'(ovr0), 1);
    chk("ovr_pulses", pulses, 1);

    // Saturation, positive then negative.
    do_reset();
    cyc(0, 0, 2'd0, 1, 2'd1, 30000);
    repeat (3) cyc(0, 1, 2'd1, 0, 2'd0, 0);
    cyc(1, 0, 2'd0, 0, 2'd0, 0);
    chk("sat_pos_d0", int'(out0), 32767);
    cyc(0, 0, 2'd0, 1, 2'd2, -32768);
    repeat (2) cyc(0, 1, 2'd2, 0, 2'd0, 0);
    cyc(1, 0, 2'd0, 0, 2'd0, 0);
    chk("sat_mid_d0", int'(out0), -16384);
    cyc(0, 0, 2'd0, 0, 2'd0, 0);
    repeat (2) cyc(0, 1, 2'd2, 0, 2'd0, 0);
    cyc(1, 0, 2'd0, 0, 2'd0, 0);
    chk("sat_neg_d0", int'(out0), -32768);
    cyc(0, 0, 2'd0, 0, 2'd0, 0);

    // Weight write racing a spike to the same id.
    do_reset();
    cyc(0, 0, 2'd0, 1, 2'd3, 5);
    cyc(0, 1, 2'd3, 1, 2'd3, 50);
    cyc(0, 1, 2'd3, 0, 2'd0, 0);
    cyc(1, 0, 2'd0, 0, 2'd0, 0);
    chk("wr_race_d0", int'(out0), 55);
    cyc(0, 0, 2'd0, 0, 2'd0, 0);

    // Reset mid-run with a sum still in the delay line.
    do_reset();
    cyc(0, 0, 2'd0, 1, 2'd0, 100);
    cyc(0, 1, 2'd0, 0, 2'd0, 0);
    cyc(1, 0, 2'd0, 0, 2'd0, 0);
    cyc(0, 0, 2'd0, 0, 2'd0, 0);
    cyc(1, 1, 2'd1, 0, 2'd0, 0);
    chk("pre_reset_d0", int'(out0), 50);
    cyc(0, 1, 2'd1, 0, 2'd0, 0);
    cyc(1, 0, 2'd0, 0, 2'd0, 0);
    do_reset();
    chk("midreset_out_d0", int'(out0), 0);
    chk("midreset_ovr", int'(ovr0), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 2'd0, 0, 2'd0, 0);
      cyc(0, 0, 2'd0, 0, 2'd0, 0);
    end
    chk("post_reset_d2", int'(out2), 0);
    chk("post_reset_d0", int'(out0), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int wd;
      case ($urandom_range(0, 3))
        0:       wd = 32767;
        1:       wd = -32768;
        2:       wd = int'($urandom_range(0, 400)) - 200;
        default: wd = int'($urandom_range(0, 65535)) - 32768;
      endcase
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            $urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), wd);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
